// File: rtl/scram_64b66b_multi_if.sv
// Beat/seed bus for the multi-lane 64b/66b scrambler.
// The master side drives beats and seeds; the slave side returns processed beats.
interface scram_64b66b_multi_if #(
  parameter int LEN   = 64,
  parameter int LANES = 1
);
  logic [LANES-1:0]     valid_i;
  logic [LANES-1:0]     bypass_i;
  logic [LANES*LEN-1:0] data_i;
  logic [LANES-1:0]     seed_load_i;
  logic [57:0]          seed_i;
  logic [LANES-1:0]     valid_o;
  logic [LANES*LEN-1:0] data_o;

  modport master (
    output valid_i, bypass_i, data_i, seed_load_i, seed_i,
    input  valid_o, data_o
  );

  modport slave (
    input  valid_i, bypass_i, data_i, seed_load_i, seed_i,
    output valid_o, data_o
  );
endinterface

// File: rtl/scram_64b66b_multi.sv
// Multi-lane self-synchronising 64b/66b scrambler/descrambler (1 + x^39 + x^58).
// Define SCRAM_OUT_REG_EN to register valid_o/data_o (latency 1); otherwise outputs are combinational.
module scram_64b66b_multi #(
  parameter int LEN     = 64,
  parameter int LANES   = 1,
  parameter int DESCRAM = 0
) (
  input logic                  clk,
  input logic                  nreset,
  scram_64b66b_multi_if.slave  bus
);

  localparam logic [57:0] STATE_ONES_C = {58{1'b1}};

  // State bit 0 holds the oldest history bit, bit 57 the most recent.
  logic [57:0]          st_r  [LANES];
  logic [57:0]          nxt_s [LANES];
  logic [LEN-1:0]       beat_s;
  logic [LANES*LEN-1:0] out_s;

  // One beat through the polynomial: w is the state followed by this beat's history bits,
  // so the x^58 tap of bit i is w[i] and the x^39 tap is w[i+19].
  function automatic logic [LEN-1:0] scram_beat(
    input  logic [57:0]    st,
    input  logic [LEN-1:0] din,
    output logic [57:0]    nxt
  );
    logic [LEN+57:0] w;
    logic [LEN-1:0]  dout;
    w        = '0;
    w[57:0]  = st;
    dout     = '0;
    for (int i = 0; i < LEN; i++) begin
      dout[i] = din[i] ^ w[i+19] ^ w[i];
      if (DESCRAM != 0) begin
        w[58+i] = din[i];
      end else begin
        w[58+i] = dout[i];
      end
    end
    nxt = w[LEN+57:LEN];
    return dout;
  endfunction

  // Per-lane data path and candidate next state
  always_comb begin
    out_s  = '0;
    beat_s = '0;
    for (int n = 0; n < LANES; n++) begin
      beat_s = scram_beat(st_r[n], bus.data_i[n*LEN +: LEN], nxt_s[n]);
      if (bus.bypass_i[n]) begin
        out_s[n*LEN +: LEN] = bus.data_i[n*LEN +: LEN];
      end else begin
        out_s[n*LEN +: LEN] = beat_s;
      end
    end
  end

  // Lane state: seed load wins over a beat update; bypass and idle beats hold
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int n = 0; n < LANES; n++) st_r[n] <= STATE_ONES_C;
    end else begin
      for (int n = 0; n < LANES; n++) begin
        if (bus.seed_load_i[n]) begin
          st_r[n] <= bus.seed_i;
        end else if (bus.valid_i[n] && !bus.bypass_i[n]) begin
          st_r[n] <= nxt_s[n];
        end else begin
          st_r[n] <= st_r[n];
        end
      end
    end
  end

`ifdef SCRAM_OUT_REG_EN
  logic [LANES-1:0]     valid_r;
  logic [LANES*LEN-1:0] data_r;

  // Output register stage
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_r <= '0;
      data_r  <= '0;
    end else begin
      valid_r <= bus.valid_i;
      data_r  <= out_s;
    end
  end

  assign bus.valid_o = valid_r;
  assign bus.data_o  = data_r;
`else
  logic [LANES-1:0]     valid_s;
  logic [LANES*LEN-1:0] data_s;

  // Combinational outputs, forced to zero while reset is held
  always_comb begin
    valid_s = '0;
    data_s  = '0;
    if (!nreset) begin
      valid_s = '0;
      data_s  = '0;
    end else begin
      valid_s = bus.valid_i;
      data_s  = out_s;
    end
  end

  assign bus.valid_o = valid_s;
  assign bus.data_o  = data_s;
`endif

endmodule
